// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage running one load or store per request over a req/ack bus
//
// Optional feature macro: LSU_BUS_TIMEOUT_EN (bus wait limit of TIMEOUT_CYCLES REQ cycles)
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start, inst_type, addr,    request from pipeline control: opcode, effective byte
//   store_data                 address and rs2 value, registered when accepted in IDLE
//   busy, done                 busy from the cycle after accept through DONE; done pulse
//   load_data                  formatted load result, held until the next accepted start
//   exc, exc_cause, exc_tval   exception flag, cause code and faulting address, held likewise
//   mem_req, mem_we, mem_addr, bus request with word-aligned address, byte enables and
//   mem_be, mem_wdata          lane-replicated write data, stable while mem_req is high
//   mem_ack, mem_rdata         bus acknowledge and read data (valid with mem_ack)

module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        inst_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              exc,
    output logic [4:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_tval,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t state, state_nxt;

    // Decode of the incoming request
    logic        dec_valid;
    logic        dec_store;
    logic        dec_signed;
    logic [1:0]  dec_size;
    logic        dec_misaligned;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic        accept;

    // Request captured at accept
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    always_comb begin
        dec_valid  = 1'b1;
        dec_store  = 1'b0;
        dec_signed = 1'b0;
        dec_size   = SZ_BYTE;
        case (inst_type)
            4'b1000: begin dec_size = SZ_BYTE; dec_signed = 1'b1; end
            4'b1001: begin dec_size = SZ_HALF; dec_signed = 1'b1; end
            4'b1010: dec_size = SZ_WORD;
            4'b1011: dec_size = SZ_BYTE;
            4'b1111: dec_size = SZ_HALF;
            4'b1100: begin dec_size = SZ_BYTE; dec_store = 1'b1; end
            4'b1101: begin dec_size = SZ_HALF; dec_store = 1'b1; end
            4'b1110: begin dec_size = SZ_WORD; dec_store = 1'b1; end
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        dec_misaligned = 1'b0;
        dec_be         = 4'b1111;
        dec_wdata      = store_data;
        case (dec_size)
            SZ_BYTE: begin
                dec_be    = 4'b0001 << addr[1:0];
                dec_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                dec_misaligned = addr[0];
                dec_be         = 4'b0011 << {addr[1], 1'b0};
                dec_wdata      = {2{store_data[15:0]}};
            end
            default: begin
                dec_misaligned = |addr[1:0];
            end
        endcase
    end

    assign accept = (state == S_IDLE) && start && dec_valid;

    // Lane selection and extension of the read word, using the captured offset
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: rd_fmt = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_fmt = {{16{signed_q & rd_half[15]}}, rd_half};
            default: rd_fmt = mem_rdata;
        endcase
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // The limit is hit in the REQ cycle that would be the TIMEOUT_CYCLES-th without ack
    assign tmo_hit = (state == S_REQ) && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ && !mem_ack && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = dec_misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_be    = be_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SZ_BYTE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            load_data <= '0;
            exc       <= 1'b0;
            exc_cause <= '0;
            exc_tval  <= '0;
        end else if (accept) begin
            we_q      <= dec_store;
            signed_q  <= dec_signed;
            size_q    <= dec_size;
            addr_q    <= addr;
            be_q      <= dec_be;
            wdata_q   <= dec_wdata;
            load_data <= '0;
            exc       <= dec_misaligned;
            exc_cause <= dec_misaligned ? (dec_store ? 5'd6 : 5'd4) : 5'd0;
            exc_tval  <= dec_misaligned ? addr : '0;
        end else if (state == S_REQ && mem_ack) begin
            load_data <= we_q ? 32'd0 : rd_fmt;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        else if (tmo_hit) begin
            exc       <= 1'b1;
            exc_cause <= we_q ? 5'd7 : 5'd5;
            exc_tval  <= addr_q;
        end
`endif
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit (directed table, random vs model, corner sequences)

module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  inst_type;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        exc;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_type(inst_type), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done), .load_data(load_data),
        .exc(exc), .exc_cause(exc_cause), .exc_tval(exc_tval), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: derived from access size and byte offset with plain arithmetic
    function automatic void model(input logic [3:0] it, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rd, output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld, output logic ex, output logic [4:0] cause);
        int size;
        bit is_load;
        bit sgn;
        int off;
        logic [31:0] raw;
        size = 4; is_load = 1; sgn = 0;
        case (it)
            4'h8: begin size = 1; sgn = 1; end
            4'h9: begin size = 2; sgn = 1; end
            4'hA: size = 4;
            4'hB: size = 1;
            4'hF: size = 2;
            4'hC: begin size = 1; is_load = 0; end
            4'hD: begin size = 2; is_load = 0; end
            default: begin size = 4; is_load = 0; end
        endcase
        off   = int'(a % 4);
        ex    = (a % size) != 0;
        be    = 4'(((1 << size) - 1) << off);
        if (size == 1)      wd = (sd & 32'hFF) * 32'h01010101;
        else if (size == 2) wd = (sd & 32'hFFFF) * 32'h00010001;
        else                wd = sd;
        raw = rd >> (8 * off);
        if (size < 4) begin
            raw = raw % (32'd1 << (8 * size));
            if (sgn && raw >= (32'd1 << (8 * size - 1))) raw = raw - (32'd1 << (8 * size));
        end
        ld    = (ex || !is_load) ? 32'd0 : raw;
        cause = ex ? (is_load ? 5'd4 : 5'd6) : 5'd0;
    endfunction

    // One transaction: start in cycle 0, dly wait cycles, inputs scrambled and start
    // held high after accept to show they are ignored
    task automatic run_txn(input logic [3:0] it, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int dly, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] ld, input logic ex,
                           input logic [4:0] cause);
        logic we;
        we = (it == 4'hC) || (it == 4'hD) || (it == 4'hE);
        @(negedge clk);
        inst_type = it; addr = a; store_data = sd; start = 1'b1;
        @(negedge clk);
        inst_type = 4'($urandom); addr = $urandom; store_data = $urandom;
        if (!ex) begin
            for (int c = 1; c <= dly + 1; c++) begin
                chk("req", mem_req, 1);
                chk("busy_req", busy, 1);
                chk("done_req", done, 0);
                chk("we", mem_we, we);
                chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_be", mem_be, be);
                if (we) chk("mem_wdata", mem_wdata, wd);
                mem_ack   = (c == dly + 1);
                mem_rdata = (c == dly + 1) ? rd : $urandom;
                addr = $urandom;
                @(negedge clk);
            end
        end
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("req_done", mem_req, 0);
        chk("load_data", load_data, ld);
        chk("exc", exc, ex);
        chk("exc_cause", exc_cause, cause);
        chk("exc_tval", exc_tval, ex ? a : 32'd0);
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        chk("load_hold", load_data, ld);
        chk("exc_hold", exc, ex);
    endtask

    typedef struct {
        logic [3:0]  it;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        logic        ex;
        logic [4:0]  cause;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [3:0]  ops[8];
        logic [3:0]  r_it, m_be;
        logic [31:0] r_a, r_sd, r_rd, m_wd, m_ld;
        logic        m_ex;
        logic [4:0]  m_cause;

        tbl[0]  = '{4'hA, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 5'd0};
        tbl[1]  = '{4'h8, 32'h103, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 5'd0};
        tbl[2]  = '{4'hB, 32'h103, 32'h0,        32'h80123456, 0, 4'b1000, 32'h0,        32'h00000080, 1'b0, 5'd0};
        tbl[3]  = '{4'hF, 32'h102, 32'h0,        32'h80123456, 0, 4'b1100, 32'h0,        32'h00008012, 1'b0, 5'd0};
        tbl[4]  = '{4'hD, 32'h202, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 5'd0};
        tbl[5]  = '{4'hC, 32'h201, 32'h55,       32'h0,        1, 4'b0010, 32'h55555555, 32'h0,        1'b0, 5'd0};
        tbl[6]  = '{4'hA, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 5'd4};
        tbl[7]  = '{4'hE, 32'h102, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 5'd6};
        tbl[8]  = '{4'h9, 32'h102, 32'h0,        32'h80123456, 0, 4'b1100, 32'h0,        32'hFFFF8012, 1'b0, 5'd0};
        tbl[9]  = '{4'hA, 32'h104, 32'h0,        32'h12345678, 3, 4'b1111, 32'h0,        32'h12345678, 1'b0, 5'd0};
        tbl[10] = '{4'h9, 32'h200, 32'h0,        32'h00007FFF, 2, 4'b0011, 32'h0,        32'h00007FFF, 1'b0, 5'd0};
        ops = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hF, 4'hC, 4'hD, 4'hE};

        rst_n = 1'b0; start = 1'b0; inst_type = 4'h0; addr = '0; store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_load", load_data, 0);
        chk("rst_exc", {exc, exc_cause}, 0);
        chk("rst_tval", exc_tval, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].it, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].dly,
                    tbl[i].be, tbl[i].wd, tbl[i].ld, tbl[i].ex, tbl[i].cause);
        end

        for (int i = 0; i < 60; i++) begin
            r_it = ops[$urandom_range(0, 7)];
            r_a  = $urandom;
            r_sd = $urandom;
            r_rd = $urandom;
            model(r_it, r_a, r_sd, r_rd, m_be, m_wd, m_ld, m_ex, m_cause);
            run_txn(r_it, r_a, r_sd, r_rd, int'($urandom_range(0, 3)), m_be, m_wd, m_ld, m_ex, m_cause);
        end

        // Undefined opcode: start ignored
        @(negedge clk);
        inst_type = 4'h5; addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("inv_busy", busy, 0);
        chk("inv_req", mem_req, 0);
        @(negedge clk);
        chk("inv_done", done, 0);

        // Reset mid-REQ: request drops at once, no done afterwards
        inst_type = 4'hA; addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mr_req", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_req_drop", mem_req, 0);
        chk("mr_busy_drop", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mr_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_idle", busy, 0);

`ifdef LSU_BUS_TIMEOUT_EN
        // Load with no ack: four REQ cycles then done with access fault
        inst_type = 4'hA; addr = 32'h300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("tmo_req", mem_req, 1);
            @(negedge clk);
        end
        chk("tmo_req_drop", mem_req, 0);
        chk("tmo_done", done, 1);
        chk("tmo_exc", exc, 1);
        chk("tmo_cause", exc_cause, 5);
        chk("tmo_tval", exc_tval, 32'h300);
        // Ack in the limit cycle wins
        run_txn(4'hE, 32'h304, 32'hCAFEF00D, 32'h0, 3, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 5'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
